clock_period_monitor: RTL and testbench
=======================================

# clock_period_monitor

Synthesizable receive-side companion to the testbench clock generators: samples an asynchronous monitored clock in the system clock domain and measures each high and low phase in system-clock cycles. Each completed period is checked against expected phase lengths within a tolerance; the block tracks lock status and counts errors. Used in simulation benches and on hardware to confirm that generated or recovered clocks have the intended period and duty cycle.

## Interface
- HI_EXP, 5: expected high-phase length, system-clock cycles
- LO_EXP, 5: expected low-phase length, system-clock cycles
- TOL, 1: allowed ± deviation per phase, cycles
- CNT_W, 16: phase counter / length output width
- LOCK_CNT, 4: consecutive good periods required to assert lock
- TIMEOUT, 1000: cycles without a detected edge before the monitored clock is declared stuck (must be < 2^CNT_W)

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- mon_clk  in  1  monitored clock, asynchronous to clock
- enable  in  1  monitor enable
- hi_len  out  CNT_W  last measured high-phase length
- lo_len  out  CNT_W  last measured low-phase length
- meas_valid  out  1  one-cycle pulse when hi_len/lo_len update
- locked  out  1  LOCK_CNT consecutive in-tolerance periods seen
- err_pulse  out  1  one-cycle pulse per bad period or timeout
- err_count  out  16  saturating error count
- stuck  out  1  timeout occurred, no edge since

## Operation
- mon_clk passes through a 2-FF synchronizer plus one history register; rise_det/fall_det are single-cycle pulses.
- Phase counter cnt: loaded with 1 on each detected edge used by the FSM, otherwise incremented; saturates at all-ones. A phase length is the value of cnt at the cycle of the next edge detection, i.e. the number of cycles between the two detections.
- FSM states:
  - IDLE: entered on reset or enable=0. Go to SYNC when enable=1.
  - SYNC: wait for rise_det, then go to MEAS_HI and set cnt=1.
  - MEAS_HI: on fall_det, latch hi_tmp=cnt, set cnt=1, go to MEAS_LO.
  - MEAS_LO: on rise_det, latch lo_tmp=cnt, set cnt=1, go to MEAS_HI, and evaluate the period.
- Evaluation: good when HI_EXP-TOL ≤ hi_tmp ≤ HI_EXP+TOL and LO_EXP-TOL ≤ lo_tmp ≤ LO_EXP+TOL. Comparisons use unsigned values at CNT_W+1 bits; a lower bound below 0 is clamped to 0.
  - Good period: good_cnt increments, saturating at LOCK_CNT. locked=1 once good_cnt reaches LOCK_CNT.
  - Bad period: good_cnt=0, locked=0, err_pulse=1, err_count+1.
- Timeout: in SYNC, MEAS_HI or MEAS_LO, when cnt reaches TIMEOUT without the awaited edge:
  - stuck=1, locked=0, good_cnt=0, err_pulse=1, err_count+1.
  - Go to SYNC with cnt=1.
  - Only one timeout is counted until an edge is seen. stuck clears on the next rise_det.
- err_count saturates at 0xFFFF.
- enable=0: FSM goes to IDLE. locked, stuck and good_cnt are cleared. hi_len, lo_len and err_count hold their values.
- A partial period in progress when enable drops or reset is asserted is discarded and never evaluated.

## Timing
- Reset values: hi_len=0, lo_len=0, meas_valid=0, locked=0, err_pulse=0, err_count=0, stuck=0; FSM state IDLE; cnt=0.
- mon_clk edge to detection pulse: 2–3 cycles. The latency is constant, so it does not bias measured lengths beyond ±1 cycle of sampling jitter.
- meas_valid, hi_len/lo_len update, err_pulse and locked/good_cnt update are all registered one cycle after the closing rise_det.
- Timeout err_pulse and stuck are registered one cycle after cnt==TIMEOUT.
- rise_det on the same cycle as cnt==TIMEOUT: the edge wins and no timeout is flagged.
- Synchronous reset overrides enable and all in-flight events.
- Minimum measurable phase is 1 cycle. Phases shorter than a system-clock period may be missed; the result is a bad period or a timeout, never a hang.

## Test plan
- Nominal: clock at 10 ns, mon_clk 50 ns high / 50 ns low, defaults, enable=1 → meas_valid every 10 cycles with hi_len=5 and lo_len=5 (±1). locked rises on the 4th meas_valid; err_count=0.
- Duty error: after lock, one period of 80 ns high / 20 ns low → meas_valid with hi_len≈8, lo_len≈2; err_pulse on that same cycle; locked=0; err_count=1. Relock after 4 further good periods.
- Stuck clock: hold mon_clk low for 1200 cycles → exactly one err_pulse, stuck=1 and locked=0 at TIMEOUT+1 cycles after the last edge; err_count increments once. stuck clears at the first rising edge once the clock resumes.
- Enable/reset mid-period: drop enable during a high phase → no meas_valid for the partial period; locked=0. Re-enable gives the first meas_valid after one full period following the first rise. A reset pulse clears err_count to 0.
- Saturation: TIMEOUT=3, enable=1, and repeatedly toggle single short bursts so that more than 65535 errors occur (or force err_count to 0xFFFE) → err_count stops at 0xFFFF while err_pulse continues to fire.

Source files
------------

// File: rtl/clock_period_monitor.sv
// rtl/clock_period_monitor.sv - measures high/low phases of an async clock in system-clock cycles
// Checks each period against expected lengths, tracks lock, counts errors and flags a stuck clock.
module clock_period_monitor #(
  parameter int HI_EXP   = 5,
  parameter int LO_EXP   = 5,
  parameter int TOL      = 1,
  parameter int CNT_W    = 16,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 1000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mon_clk,
  input  logic             enable,
  output logic [CNT_W-1:0] hi_len,
  output logic [CNT_W-1:0] lo_len,
  output logic             meas_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic [15:0]      err_count,
  output logic             stuck
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W:0] HI_MIN = (HI_EXP > TOL) ? (CNT_W+1)'(HI_EXP - TOL) : '0;
  localparam logic [CNT_W:0] HI_MAX = (CNT_W+1)'(HI_EXP + TOL);
  localparam logic [CNT_W:0] LO_MIN = (LO_EXP > TOL) ? (CNT_W+1)'(LO_EXP - TOL) : '0;
  localparam logic [CNT_W:0] LO_MAX = (CNT_W+1)'(LO_EXP + TOL);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
  localparam logic [GW-1:0] LOCK_V = GW'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, SYNC, MEAS_HI, MEAS_LO} state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, hist_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_tmp_q, hi_tmp_d;
  logic [CNT_W-1:0] hi_len_q, hi_len_d;
  logic [CNT_W-1:0] lo_len_q, lo_len_d;
  logic             meas_valid_q, meas_valid_d;
  logic [GW-1:0]    good_cnt_q, good_cnt_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [15:0]      err_count_q, err_count_d;
  logic             stuck_q, stuck_d;

  logic             rise_det, fall_det, period_good, to_hit;
  logic [CNT_W-1:0] cnt_inc;
  logic [GW-1:0]    good_inc;
  logic [15:0]      err_inc;

  assign rise_det = s2_q & ~hist_q;
  assign fall_det = ~s2_q & hist_q;
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign good_inc = (good_cnt_q == LOCK_V) ? good_cnt_q : good_cnt_q + GW'(1);
  assign err_inc  = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;
  // Only one timeout per outage: stuck stays set until the next rising edge.
  assign to_hit   = (cnt_q == TO_VAL) && !stuck_q;
  assign period_good = ({1'b0, hi_tmp_q} >= HI_MIN) && ({1'b0, hi_tmp_q} <= HI_MAX) &&
                       ({1'b0, cnt_q} >= LO_MIN) && ({1'b0, cnt_q} <= LO_MAX);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_inc;
    hi_tmp_d     = hi_tmp_q;
    hi_len_d     = hi_len_q;
    lo_len_d     = lo_len_q;
    meas_valid_d = 1'b0;
    good_cnt_d   = good_cnt_q;
    locked_d     = locked_q;
    err_pulse_d  = 1'b0;
    err_count_d  = err_count_q;
    stuck_d      = stuck_q & ~rise_det;
    if (!enable) begin
      state_d    = IDLE;
      cnt_d      = '0;
      good_cnt_d = '0;
      locked_d   = 1'b0;
      stuck_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = SYNC;
        end
        SYNC: begin
          if (rise_det) begin
            cnt_d   = CNT_W'(1);
            state_d = MEAS_HI;
          end
        end
        MEAS_HI: begin
          if (fall_det) begin
            hi_tmp_d = cnt_q;
            cnt_d    = CNT_W'(1);
            state_d  = MEAS_LO;
          end
        end
        MEAS_LO: begin
          if (rise_det) begin
            cnt_d        = CNT_W'(1);
            state_d      = MEAS_HI;
            hi_len_d     = hi_tmp_q;
            lo_len_d     = cnt_q;
            meas_valid_d = 1'b1;
            if (period_good) begin
              good_cnt_d = good_inc;
              locked_d   = (good_inc == LOCK_V);
            end else begin
              good_cnt_d  = '0;
              locked_d    = 1'b0;
              err_pulse_d = 1'b1;
              err_count_d = err_inc;
            end
          end
        end
        default: state_d = IDLE;
      endcase
      // The awaited edge was not taken above, so the phase has run too long.
      if (state_q != IDLE && state_d == state_q && to_hit) begin
        stuck_d     = 1'b1;
        locked_d    = 1'b0;
        good_cnt_d  = '0;
        err_pulse_d = 1'b1;
        err_count_d = err_inc;
        state_d     = SYNC;
        cnt_d       = CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      hist_q       <= 1'b0;
      cnt_q        <= '0;
      hi_tmp_q     <= '0;
      hi_len_q     <= '0;
      lo_len_q     <= '0;
      meas_valid_q <= 1'b0;
      good_cnt_q   <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_count_q  <= '0;
      stuck_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_q         <= mon_clk;
      s2_q         <= s1_q;
      hist_q       <= s2_q;
      cnt_q        <= cnt_d;
      hi_tmp_q     <= hi_tmp_d;
      hi_len_q     <= hi_len_d;
      lo_len_q     <= lo_len_d;
      meas_valid_q <= meas_valid_d;
      good_cnt_q   <= good_cnt_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      err_count_q  <= err_count_d;
      stuck_q      <= stuck_d;
    end
  end

  assign hi_len     = hi_len_q;
  assign lo_len     = lo_len_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign err_count  = err_count_q;
  assign stuck      = stuck_q;

endmodule

// File: tb/tb_clock_period_monitor.sv
// tb/tb_clock_period_monitor.sv - directed bench for clock_period_monitor
module tb_clock_period_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mon_clk = 1'b0, enable = 1'b0;
  logic        mon_clk2 = 1'b0, enable2 = 1'b0;
  logic [15:0] hi_len, lo_len, err_count, hi_len2, lo_len2, err_count2;
  logic        meas_valid, locked, err_pulse, stuck;
  logic        meas_valid2, locked2, err_pulse2, stuck2;

  always #5 clk = ~clk;

  clock_period_monitor dut (
    .clock(clk), .reset(reset), .mon_clk(mon_clk), .enable(enable),
    .hi_len(hi_len), .lo_len(lo_len), .meas_valid(meas_valid), .locked(locked),
    .err_pulse(err_pulse), .err_count(err_count), .stuck(stuck)
  );

  clock_period_monitor #(.TIMEOUT(3)) dut2 (
    .clock(clk), .reset(reset), .mon_clk(mon_clk2), .enable(enable2),
    .hi_len(hi_len2), .lo_len(lo_len2), .meas_valid(meas_valid2), .locked(locked2),
    .err_pulse(err_pulse2), .err_count(err_count2), .stuck(stuck2)
  );

  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int cyc = 0, mv_cnt = 0, ep_cnt = 0, ep2_cnt = 0, lock_at = 0, per_cnt = 0;
  int mv_t0 = 0, mv_t1 = 0;
  logic [15:0] last_hi = '0, last_lo = '0;
  logic ep_with_mv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (meas_valid) begin
      mv_cnt  <= mv_cnt + 1;
      last_hi <= hi_len;
      last_lo <= lo_len;
      mv_t0   <= mv_t1;
      mv_t1   <= cyc;
      if (locked && lock_at == 0) lock_at <= mv_cnt + 1;
    end
    if (err_pulse) begin
      ep_cnt     <= ep_cnt + 1;
      ep_with_mv <= meas_valid;
    end
    if (err_pulse2) ep2_cnt <= ep2_cnt + 1;
  end

  // Pattern generator: whole periods of hi_cyc/lo_cyc cycles, with an optional one-shot period.
  bit gen_run = 0, shot = 0;
  int hi_cyc = 5, lo_cyc = 5, shot_h = 8, shot_l = 2, gh, gl;
  initial forever begin
    if (gen_run) begin
      gh = hi_cyc;
      gl = lo_cyc;
      if (shot) begin
        gh = shot_h;
        gl = shot_l;
        shot = 0;
      end
      per_cnt++;
      mon_clk = 1'b1;
      repeat (gh) @(negedge clk);
      mon_clk = 1'b0;
      repeat (gl) @(negedge clk);
    end else begin
      @(negedge clk);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_mv(input int target, input int budget, input string tag);
    int g = 0;
    while (mv_cnt < target && g < budget) begin
      tick(1);
      g++;
    end
    check(tag, 32'(mv_cnt >= target), 32'd1);
  endtask

  int base, e0, mv0, p0, g;

  initial begin
    tick(3);
    check("rst_hi_len", 32'(hi_len), 32'd0);
    check("rst_lo_len", 32'(lo_len), 32'd0);
    check("rst_meas_valid", 32'(meas_valid), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err_pulse", 32'(err_pulse), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_stuck", 32'(stuck), 32'd0);
    reset = 1'b0;

    // Nominal 5/5 clock
    enable = 1'b1;
    tick(1);
    gen_run = 1;
    wait_mv(4, 100, "nom_wait");
    check("nom_lock_at", 32'(lock_at), 32'd4);
    check("nom_hi", 32'(last_hi), 32'd5);
    check("nom_lo", 32'(last_lo), 32'd5);
    check("nom_interval", 32'(mv_t1 - mv_t0), 32'd10);
    check("nom_locked", 32'(locked), 32'd1);
    check("nom_err_count", 32'(err_count), 32'd0);
    check("nom_no_err_pulse", 32'(ep_cnt), 32'd0);

    // One 8/2 period after lock
    e0 = ep_cnt;
    shot = 1;
    g = 0;
    while (ep_cnt == e0 && g < 60) begin
      tick(1);
      g++;
    end
    check("duty_err_seen", 32'(ep_cnt - e0), 32'd1);
    check("duty_err_with_mv", 32'(ep_with_mv), 32'd1);
    check("duty_hi", 32'(last_hi), 32'd8);
    check("duty_lo", 32'(last_lo), 32'd2);
    check("duty_locked", 32'(locked), 32'd0);
    check("duty_err_count", 32'(err_count), 32'd1);
    base = mv_cnt;
    wait_mv(base + 3, 60, "relock_wait3");
    check("relock_not_yet", 32'(locked), 32'd0);
    wait_mv(base + 4, 30, "relock_wait4");
    check("relock_locked", 32'(locked), 32'd1);
    check("relock_err_count", 32'(err_count), 32'd1);

    // Stuck-low clock
    gen_run = 0;
    e0 = ep_cnt;
    tick(1200);
    check("stuck_one_err", 32'(ep_cnt - e0), 32'd1);
    check("stuck_flag", 32'(stuck), 32'd1);
    check("stuck_locked", 32'(locked), 32'd0);
    check("stuck_err_count", 32'(err_count), 32'd2);
    gen_run = 1;
    g = 0;
    while (stuck && g < 20) begin
      tick(1);
      g++;
    end
    check("stuck_cleared", 32'(stuck), 32'd0);
    check("resume_err_count", 32'(err_count), 32'd2);

    // Enable drop during a high phase
    base = mv_cnt;
    wait_mv(base + 5, 120, "en_lock_wait");
    check("en_locked_before", 32'(locked), 32'd1);
    p0 = per_cnt;
    g = 0;
    while (per_cnt == p0 && g < 20) begin
      tick(1);
      g++;
    end
    tick(4);
    enable = 1'b0;
    mv0 = mv_cnt;
    tick(12);
    check("dis_no_mv", 32'(mv_cnt), 32'(mv0));
    check("dis_locked", 32'(locked), 32'd0);
    check("dis_hi_hold", 32'(hi_len), 32'd5);
    check("dis_err_hold", 32'(err_count), 32'd2);
    enable = 1'b1;
    wait_mv(mv0 + 1, 60, "reen_mv_wait");
    check("reen_hi", 32'(last_hi), 32'd5);
    check("reen_lo", 32'(last_lo), 32'd5);
    check("reen_err_count", 32'(err_count), 32'd2);
    check("reen_locked", 32'(locked), 32'd0);

    // Reset pulse
    reset = 1'b1;
    tick(2);
    check("rst2_err_count", 32'(err_count), 32'd0);
    check("rst2_hi_len", 32'(hi_len), 32'd0);
    check("rst2_locked", 32'(locked), 32'd0);
    reset = 1'b0;
    gen_run = 0;

    // Saturation on a TIMEOUT=3 instance
    enable2 = 1'b1;
    tick(10);
    check("to3_single_err", 32'(ep2_cnt), 32'd1);
    check("to3_err_count", 32'(err_count2), 32'd1);
    check("to3_stuck", 32'(stuck2), 32'd1);
    force dut2.err_count_q = 16'hFFFE;
    tick(1);
    release dut2.err_count_q;
    tick(1);
    check("sat_preset", 32'(err_count2), 32'hFFFE);
    e0 = ep2_cnt;
    for (int i = 0; i < 30; i++) begin
      mon_clk2 = ~mon_clk2;
      @(negedge clk);
    end
    tick(4);
    check("sat_count", 32'(err_count2), 32'hFFFF);
    check("sat_pulses_continue", 32'(ep2_cnt - e0 >= 5), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
